// File: rtl/struct_op_pkg.sv
`default_nettype none
// ============================================================================
// Module     : struct_op_pkg
// Purpose    : Shared types for the struct_op_arbiter block: the packed
//              operand pair carried by each requester and the arbiter FSM
//              state encoding.
// Ports      : none (package)
// Revision   : 1.0 - initial release
// ============================================================================
package struct_op_pkg;

  // Default operand width; the top-level DATA_W parameter defaults to this
  // and must stay equal to it, because op_t is sized from it.
  localparam int OP_DATA_W = 16;

  // Operand pair as presented on each request port: {data_A, data_B}.
  typedef struct packed {
    logic [OP_DATA_W-1:0] data_A;
    logic [OP_DATA_W-1:0] data_B;
  } op_t;

  // Arbiter FSM: explicit 2-bit encoding.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Width of a requester index; a single requester still gets a 1-bit ID.
  function automatic int id_width(input int num_req);
    return (num_req > 1) ? $clog2(num_req) : 1;
  endfunction

endpackage : struct_op_pkg
`default_nettype wire

// File: rtl/struct_op_arbiter_rr.sv
`default_nettype none
// ============================================================================
// Module     : rr_arbiter
// Purpose    : Combinational round-robin picker. Scans the request vector
//              circularly starting at rr_ptr_i and selects the first set bit.
// Ports      : req_i      in  NUM_REQ  request vector
//              rr_ptr_i   in  ID_W     index with highest priority this cycle
//              gnt_o      out NUM_REQ  one-hot grant (all zero if no request)
//              gnt_idx_o  out ID_W     index of the granted requester
//              gnt_vld_o  out 1        any request present
// Revision   : 1.0 - initial release
// ============================================================================
module rr_arbiter
  import struct_op_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = id_width(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [ID_W-1:0]    rr_ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [ID_W-1:0]    gnt_idx_o,
  output logic               gnt_vld_o
);

  // One extra bit so ptr + offset cannot overflow before the modulo fold.
  logic [ID_W:0] cand_w;

  always_comb begin
    gnt_o     = '0;
    gnt_idx_o = '0;
    gnt_vld_o = 1'b0;
    cand_w    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      // rr_ptr_i < NUM_REQ, so a single conditional subtract is a full modulo.
      cand_w = {1'b0, rr_ptr_i} + (ID_W+1)'(i);
      if (cand_w >= (ID_W+1)'(NUM_REQ)) begin
        cand_w = cand_w - (ID_W+1)'(NUM_REQ);
      end
      if (!gnt_vld_o && req_i[cand_w[ID_W-1:0]]) begin
        gnt_vld_o = 1'b1;
        gnt_idx_o = cand_w[ID_W-1:0];
      end
    end
    if (gnt_vld_o) begin
      gnt_o[gnt_idx_o] = 1'b1;
    end
  end

endmodule : rr_arbiter
`default_nettype wire

// File: rtl/struct_op_arbiter.sv
`default_nettype none
// ============================================================================
// Module     : struct_op_arbiter
// Purpose    : Shares one add/compare datapath among NUM_REQ requesters with
//              round-robin arbitration. One transaction in flight; the result
//              is returned on a single valid/ready response port tagged with
//              the owning requester's index.
// Ports      : clk        in  1              rising-edge clock
//              rst        in  1              synchronous active-high reset
//              req_valid  in  NUM_REQ        per-requester request valid
//              req_ready  out NUM_REQ        per-requester accept (<= 1 hot)
//              req_op     in  NUM_REQ x op_t per-requester {data_A, data_B}
//              rsp_valid  out 1              response valid
//              rsp_ready  in  1              response accepted by consumer
//              rsp_id     out ID_W           owner of the response
//              rsp_sum    out DATA_W+1       data_A + data_B, carry in MSB
//              rsp_is_eq  out 1              data_A == data_B
//              busy       out 1              FSM not in IDLE
// Revision   : 1.0 - initial release
// ============================================================================
module struct_op_arbiter
  import struct_op_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  parameter  int DATA_W  = OP_DATA_W,
  localparam int ID_W    = id_width(NUM_REQ)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NUM_REQ-1:0]  req_valid,
  output logic [NUM_REQ-1:0]  req_ready,
  input  op_t  [NUM_REQ-1:0]  req_op,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [ID_W-1:0]     rsp_id,
  output logic [DATA_W:0]     rsp_sum,
  output logic                rsp_is_eq,
  output logic                busy
);

  // --------------------------------------------------------------------------
  // State and registers
  // --------------------------------------------------------------------------
  arb_state_t          state_q,     state_d;
  logic [ID_W-1:0]     rr_ptr_q,    rr_ptr_d;
  op_t                 op_q,        op_d;
  logic [ID_W-1:0]     id_q,        id_d;
  logic                rsp_valid_q, rsp_valid_d;
  logic [ID_W-1:0]     rsp_id_q,    rsp_id_d;
  logic [DATA_W:0]     rsp_sum_q,   rsp_sum_d;
  logic                rsp_is_eq_q, rsp_is_eq_d;

  // --------------------------------------------------------------------------
  // Arbiter
  // --------------------------------------------------------------------------
  logic [NUM_REQ-1:0]  gnt_w;
  logic [ID_W-1:0]     gnt_idx_w;
  logic                gnt_vld_w;
  logic [ID_W-1:0]     ptr_next_w;

  rr_arbiter #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_rr_arbiter (
    .req_i     (req_valid),
    .rr_ptr_i  (rr_ptr_q),
    .gnt_o     (gnt_w),
    .gnt_idx_o (gnt_idx_w),
    .gnt_vld_o (gnt_vld_w)
  );

  // Pointer moves to the slot just after the winner so the winner becomes
  // lowest priority next time; wraps from NUM_REQ-1 to 0.
  assign ptr_next_w = (gnt_idx_w == ID_W'(NUM_REQ - 1)) ? '0
                                                         : gnt_idx_w + 1'b1;

  // --------------------------------------------------------------------------
  // Datapath: zero-extend both operands so the carry lands in the MSB.
  // --------------------------------------------------------------------------
  logic [DATA_W:0] sum_w;
  logic            eq_w;

  assign sum_w = {1'b0, op_q.data_A} + {1'b0, op_q.data_B};
  assign eq_w  = (op_q.data_A == op_q.data_B);

  // --------------------------------------------------------------------------
  // FSM next-state and outputs
  // --------------------------------------------------------------------------
  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    op_d        = op_q;
    id_d        = id_q;
    rsp_valid_d = rsp_valid_q;
    rsp_id_d    = rsp_id_q;
    rsp_sum_d   = rsp_sum_q;
    rsp_is_eq_d = rsp_is_eq_q;
    req_ready   = '0;

    case (state_q)
      IDLE: begin
        // Grant vector is already zero when nothing is requesting.
        req_ready = gnt_w;
        if (gnt_vld_w) begin
          op_d     = req_op[gnt_idx_w];
          id_d     = gnt_idx_w;
          rr_ptr_d = ptr_next_w;
          state_d  = EXEC;
        end
      end

      EXEC: begin
        rsp_sum_d   = sum_w;
        rsp_is_eq_d = eq_w;
        rsp_id_d    = id_q;
        rsp_valid_d = 1'b1;
        state_d     = RESP;
      end

      RESP: begin
        // Result registers are left untouched after the handshake so the
        // last result stays visible until the next EXEC.
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end

      default: begin
        state_d     = IDLE;
        rsp_valid_d = 1'b0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      op_q        <= '0;
      id_q        <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_sum_q   <= '0;
      rsp_is_eq_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      op_q        <= op_d;
      id_q        <= id_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_id_q    <= rsp_id_d;
      rsp_sum_q   <= rsp_sum_d;
      rsp_is_eq_q <= rsp_is_eq_d;
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_id    = rsp_id_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_is_eq = rsp_is_eq_q;
  assign busy      = (state_q != IDLE);

endmodule : struct_op_arbiter
`default_nettype wire
